// File: rtl/w5_rom_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : w5_rom_rd_ctrl
// Brief    : Read sequencer for the F5 weight ROM. Streams a contiguous run of
//            ROM rows to the MAC array over valid/ready, hiding the ROM read
//            latency behind a credit-controlled output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module w5_rom_rd_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 960,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   row_cnt,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] w5_raddr,
    input  logic [DATA_W-1:0] w5_rdata,
    output logic [DATA_W-1:0] wt_data,
    output logic              wt_valid,
    input  logic              wt_ready,
    output logic              wt_last
);

    localparam int c_PW = $clog2(FIFO_DEPTH);       // FIFO pointer width
    localparam int c_CW = $clog2(FIFO_DEPTH + 1);   // FIFO occupancy width
    localparam int c_OW = c_CW + 1;                 // occupancy + in-flight
    localparam int c_RW = ADDR_W + 1;               // remaining-row counter
    localparam logic [c_OW-1:0] c_DEPTH = c_OW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_RW-1:0]     r_remain;
    logic [ADDR_W-1:0]   r_raddr;
    logic [RD_LAT-1:0]   r_vld;
    logic [RD_LAT-1:0]   r_lst;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_mem_last;
    logic [c_PW-1:0]     r_wptr;
    logic [c_PW-1:0]     r_rptr;
    logic [c_CW-1:0]     r_cnt;
    logic                r_done;

    logic [c_CW-1:0]     w_inflight;
    logic [c_OW-1:0]     w_used;
    logic                w_credit;
    logic                w_push;
    logic                w_pop;
    logic                w_issue;
    logic                w_issue_last;
    logic                w_load;
    logic                w_zero;
    logic                w_fin;

    // Credit: FIFO occupancy plus reads still in the ROM pipe, no pop credit.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + c_CW'(r_vld[i]);
        end
        w_used   = c_OW'(r_cnt) + c_OW'(w_inflight);
        w_credit = (w_used < c_DEPTH);
    end

    assign w_push   = r_vld[RD_LAT-1];
    assign wt_valid = (r_cnt != '0);
    assign wt_data  = r_mem[r_rptr];
    assign wt_last  = wt_valid & r_mem_last[r_rptr];
    assign w_pop    = wt_valid & wt_ready;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign w5_raddr = r_raddr;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state, command acceptance and read-issue decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_issue_last = 1'b0;
        w_load       = 1'b0;
        w_zero       = 1'b0;
        w_fin        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (row_cnt != '0) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_zero = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if ((r_remain != '0) && w_credit) begin
                    w_issue = 1'b1;
                    if (r_remain == c_RW'(1)) begin
                        w_issue_last = 1'b1;
                        w_state_nxt  = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && wt_last) begin
                    w_fin       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address and remaining-row counters; address wraps at 2^ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raddr  <= '0;
            r_remain <= '0;
        end else if (w_load) begin
            r_raddr  <= base_addr;
            r_remain <= row_cnt;
        end else if (w_issue) begin
            r_raddr  <= r_raddr + ADDR_W'(1);
            r_remain <= r_remain - c_RW'(1);
        end
    end

    // In-flight valid / last-row shift registers matching the ROM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_lst <= '0;
        end else begin
            r_vld <= (r_vld << 1) | RD_LAT'(w_issue);
            r_lst <= (r_lst << 1) | RD_LAT'(w_issue_last);
        end
    end

    // FIFO pointers, occupancy and the completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PW'(1);
            if (w_pop)  r_rptr <= r_rptr + c_PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_CW'(1);
                2'b01:   r_cnt <= r_cnt - c_CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            r_done <= w_fin | w_zero;
        end
    end

    // Row storage is not reset; reads are qualified by wt_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr]      <= w5_rdata;
            r_mem_last[r_wptr] <= r_lst[RD_LAT-1];
        end
    end

    // Credit gating must make a push into a full FIFO impossible.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_cnt == c_CW'(FIFO_DEPTH))));

endmodule
`default_nettype wire

// File: doc/w5_rom_rd_ctrl.md
# w5_rom_rd_ctrl

Read sequencer for the F5 weight ROM (`w5_rom`, 9-bit address, 960-bit row). On a start command it streams a contiguous run of ROM rows to the downstream MAC array over a valid/ready interface. It hides the ROM's fixed read latency and absorbs downstream backpressure with a small credit-controlled FIFO, so no row is lost or duplicated. It sits between the layer-level control FSM and `w5_rom`/MAC datapath.

## Interface
- `ADDR_W`, 9, ROM address width.
- `DATA_W`, 960, ROM row width.
- `RD_LAT`, 1, ROM read latency in cycles (1 or 2); must match the ROM core configuration.
- `FIFO_DEPTH`, 4, output buffer entries; power of two, ≥ RD_LAT+1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle command strobe; ignored while `busy`=1.
- `base_addr` input ADDR_W: first row, sampled with `start`.
- `row_cnt` input ADDR_W+1: rows to read, 0..512, sampled with `start`.
- `busy` output 1: command in progress.
- `done` output 1: one-cycle pulse at command completion.
- `w5_raddr` output ADDR_W: ROM address, registered.
- `w5_rdata` input DATA_W: ROM data, valid RD_LAT cycles after its address cycle.
- `wt_data` output DATA_W: FIFO head row.
- `wt_valid` output 1: `wt_data` valid.
- `wt_ready` input 1: downstream accepts; transfer when `wt_valid`&`wt_ready`.
- `wt_last` output 1: qualifies the final row of the command.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `start` with `row_cnt`≠0 latches address and remaining count, then moves to RUN. `start` with `row_cnt`=0 pulses `done` next cycle; `busy` stays 0.
- RUN: a read issues in a cycle when remaining>0 and (FIFO occupancy + in-flight reads) < FIFO_DEPTH. Occupancy is evaluated without same-cycle pop credit.
- When a read issues, `w5_raddr` holds the address in that cycle, then increments modulo 2^ADDR_W (511 wraps to 0), and remaining decrements.
- In-flight tracking: an RD_LAT-deep valid shift register. The ROM output is written to the FIFO at the end of cycle issue+RD_LAT. The last-row flag travels alongside each read.
- RUN goes to DRAIN when the last read issues. DRAIN goes to IDLE on the `wt_last` handshake.
- `done` pulses in the cycle after the `wt_last` handshake. `busy` is 1 from the cycle after `start` through the `wt_last` handshake cycle, and is 0 in the `done` cycle.
- `wt_valid` and `wt_data` are held stable until accepted.
- FIFO write and pop in the same cycle is legal, including full/empty boundaries. Credit gating makes overflow impossible; an overflow is an assertion failure.
- `w5_raddr` keeps its last value when idle.

## Timing
- Reset values: `busy`=0, `done`=0, `wt_valid`=0, `wt_last`=0, `w5_raddr`=0, state IDLE, counters and pointers 0.
- `wt_data` storage is not reset. Checks on `wt_data` apply only when `wt_valid`=1.
- Latency, with `start` sampled in cycle s, empty FIFO and RD_LAT=1:
  - first `w5_raddr` in cycle s+1;
  - first `wt_valid` in cycle s+3 (no fall-through);
  - in general, first `wt_valid` at s+2+RD_LAT.
- Throughput: one row per cycle with `wt_ready`=1, provided FIFO_DEPTH ≥ RD_LAT+2. The defaults meet this.
- Reset mid-command: everything returns immediately to reset values, with no `done` pulse. In-flight ROM data arriving after reset release is discarded.

## Test plan
- Basic run: base=10, cnt=4, `wt_ready`=1, start at s.
  - `w5_raddr` = 10,11,12,13 in s+1..s+4.
  - `wt_valid` in s+3..s+6, carrying ROM rows 10..13.
  - `wt_last` in s+6, `done` in s+7.
- Backpressure: base=0, cnt=20, `wt_ready`=0 for cycles s+1..s+12, then random.
  - Issues stop once 4 reads are outstanding.
  - All 20 rows are delivered in order, with no duplicates.
  - `wt_data` is stable while stalled.
- Wrap: base=510, cnt=4 -> addresses 510, 511, 0, 1; data matches those rows.
- Zero count: cnt=0 -> `done` pulses at s+1; `busy` and `wt_valid` never rise; `w5_raddr` is unchanged.
- Start while busy: a second `start` mid-run (base=100) is ignored. Only the original rows appear, followed by exactly one `done`.
- Full sweep plus reset:
  - base=0, cnt=512 with `wt_ready`=1 yields 512 consecutive beats and `wt_last` on row 511.
  - A repeat run with `rst_n` asserted mid-burst clears all outputs asynchronously.
  - A new command after reset streams correctly with no stale data.
